// File: rtl/huffman_symbol_counter.sv
// Frequency-counting front end of the Huffman encoder: latches a 256-nibble block,
// counts symbols 1..10 one nibble per clock and publishes a packed {symbol, freq} table.
module huffman_symbol_counter (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          input_over,
  input  logic [1023:0] CHARACTER_IN,
  output logic [129:0]  FREQUENT_OUT,
  output logic          count_over
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [1023:0]  latched;
  logic [1023:0]  latched_next;
  logic [7:0]     idx;
  logic [7:0]     idx_next;
  logic [8:0]     counts [10];
  logic [8:0]     counts_next [10];
  logic [129:0]   table_next;
  logic           done_next;
  logic [3:0]     nibble;

  assign nibble = latched[{idx, 2'b00} +: 4];

  // Padding (0) and out-of-alphabet values (11..15) match no slot, so they fall through untouched.
  always_comb begin
    state_next   = state;
    latched_next = latched;
    idx_next     = idx;
    counts_next  = counts;
    table_next   = FREQUENT_OUT;
    done_next    = count_over;

    case (state)
      IDLE: begin
        idx_next = 8'd0;
        for (int k = 0; k < 10; k++) begin
          counts_next[k] = 9'd0;
        end
        if (input_over) begin
          latched_next = CHARACTER_IN;
          state_next   = COUNT;
        end
      end

      COUNT: begin
        for (int k = 0; k < 10; k++) begin
          if (nibble == 4'(k + 1)) begin
            counts_next[k] = counts[k] + 9'd1;
          end
        end
        idx_next = idx + 8'd1;
        // The table is built from counts_next so the last nibble is already included.
        if (idx == 8'd255) begin
          state_next = DONE;
          done_next  = 1'b1;
          for (int k = 0; k < 10; k++) begin
            table_next[13*k +: 13] = {4'(k + 1), counts_next[k]};
          end
        end
      end

      DONE: begin
        idx_next = idx;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= IDLE;
      latched      <= '0;
      idx          <= 8'd0;
      FREQUENT_OUT <= '0;
      count_over   <= 1'b0;
      for (int k = 0; k < 10; k++) begin
        counts[k] <= 9'd0;
      end
    end else begin
      state        <= state_next;
      latched      <= latched_next;
      idx          <= idx_next;
      FREQUENT_OUT <= table_next;
      count_over   <= done_next;
      for (int k = 0; k < 10; k++) begin
        counts[k] <= counts_next[k];
      end
    end
  end

endmodule

// File: tb/tb_huffman_symbol_counter.sv
// Self-checking bench for huffman_symbol_counter: directed and random blocks compared
// against a per-symbol tally model; timing checked as edge counts from the capture edge.
module tb_huffman_symbol_counter;

  logic          CLK;
  logic          nRST;
  logic          input_over;
  logic [1023:0] CHARACTER_IN;
  logic [129:0]  FREQUENT_OUT;
  logic          count_over;

  int passed = 0;
  int total  = 0;

  huffman_symbol_counter dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .input_over   (input_over),
    .CHARACTER_IN (CHARACTER_IN),
    .FREQUENT_OUT (FREQUENT_OUT),
    .count_over   (count_over)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [129:0] obs, input logic [129:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [129:0] pack_counts(input int c [10]);
    logic [129:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      r[13*k +: 13] = {4'(k + 1), 9'(c[k])};
    end
    return r;
  endfunction

  // Reference: tally each nibble value that lies in the alphabet 1..10.
  function automatic logic [129:0] model(input logic [1023:0] blk);
    int c [10];
    int v;
    for (int k = 0; k < 10; k++) c[k] = 0;
    for (int i = 0; i < 256; i++) begin
      v = int'(blk[4*i +: 4]);
      if (v >= 1 && v <= 10) c[v-1]++;
    end
    return pack_counts(c);
  endfunction

  function automatic logic [1023:0] rand_block(input int maxv);
    logic [1023:0] b;
    for (int i = 0; i < 256; i++) begin
      b[4*i +: 4] = 4'($urandom_range(0, maxv));
    end
    return b;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    nRST = 1'b0;
    step();
    check_output({tag, " reset table"}, FREQUENT_OUT, '0);
    check_output({tag, " reset count_over"}, 130'(count_over), '0);
    nRST = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [1023:0] blk, input logic [129:0] expected,
                                input string tag, input int change_at);
    int  rise_edge;
    bit  leak;
    CHARACTER_IN = blk;
    input_over   = 1'b1;
    step();
    input_over = 1'b0;
    rise_edge  = -1;
    leak       = 1'b0;
    for (int e = 1; e <= 300 && rise_edge < 0; e++) begin
      if (e == change_at) CHARACTER_IN = rand_block(15);
      step();
      if (count_over) rise_edge = e;
      else if (FREQUENT_OUT !== '0) leak = 1'b1;
    end
    check_output({tag, " latency"}, 130'(rise_edge), 130'(256));
    check_output({tag, " table zero before done"}, 130'(leak), '0);
    check_output({tag, " table"}, FREQUENT_OUT, expected);
  endtask

  initial begin
    int            ref_vals [31] = '{1,2,3,4,5,1,1,1,2,1,2,1,2,3,1,2,3,4,1,2,3,4,1,2,3,4,1,2,3,4,5};
    int            cnt [10];
    logic [1023:0] blk;
    logic [1023:0] blk_b;
    logic [129:0]  exp_tab;
    bit            leak;

    blk = '0;
    for (int i = 0; i < 31; i++) blk[4*i +: 4] = 4'(ref_vals[i]);
    nRST         = 1'b0;
    input_over   = 1'b1;
    CHARACTER_IN = blk;
    step();
    apply_reset("ref");
    cnt     = '{10, 8, 6, 5, 2, 0, 0, 0, 0, 0};
    exp_tab = pack_counts(cnt);
    apply_stimulus(blk, exp_tab, "ref", 0);

    $display("[TB] checking DONE holds against new input");
    input_over   = 1'b1;
    CHARACTER_IN = rand_block(10);
    for (int i = 0; i < 20; i++) step();
    check_output("done hold table", FREQUENT_OUT, exp_tab);
    check_output("done hold count_over", 130'(count_over), 130'(1));

    apply_reset("zero");
    cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus('0, pack_counts(cnt), "zero", 0);

    apply_reset("sevens");
    cnt = '{0, 0, 0, 0, 0, 0, 256, 0, 0, 0};
    apply_stimulus({256{4'h7}}, pack_counts(cnt), "sevens", 0);

    apply_reset("mixed");
    for (int i = 0; i < 256; i++) blk[4*i +: 4] = (i % 2 == 1) ? 4'd10 : 4'(11 + (i % 5));
    cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 128};
    apply_stimulus(blk, pack_counts(cnt), "mixed", 0);

    $display("[TB] idle with input_over low");
    input_over = 1'b0;
    apply_reset("idle");
    leak = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (count_over !== 1'b0 || FREQUENT_OUT !== '0) leak = 1'b1;
    end
    check_output("idle outputs stay zero", 130'(leak), '0);
    blk = rand_block(15);
    apply_stimulus(blk, model(blk), "idle late start", 0);

    $display("[TB] reset in the middle of counting");
    apply_reset("abort");
    CHARACTER_IN = {256{4'h3}};
    input_over   = 1'b1;
    step();
    input_over = 1'b0;
    for (int i = 1; i < 100; i++) step();
    nRST = 1'b0;
    step();
    check_output("abort table zero", FREQUENT_OUT, '0);
    check_output("abort count_over zero", 130'(count_over), '0);
    nRST  = 1'b1;
    blk_b = rand_block(10);
    apply_stimulus(blk_b, model(blk_b), "after abort", 0);

    apply_reset("change");
    blk = rand_block(12);
    apply_stimulus(blk, model(blk), "input change", 5);

    for (int r = 0; r < 3; r++) begin
      apply_reset("random");
      blk = rand_block((r == 0) ? 10 : 15);
      apply_stimulus(blk, model(blk), "random", 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/huffman_symbol_counter.md
# huffman_symbol_counter

Frequency-counting front end of the Huffman encoder. It captures a 256-symbol block of 4-bit characters and counts the occurrences of each symbol value 1..10 by scanning the block one nibble per clock. It then presents a packed 10-entry {symbol, frequency} table to the downstream sort/tree-build stage and flags completion.

## Interface
Parameters: none; all widths are fixed.

- CLK  in  1  — single clock; all state changes on the rising edge.
- nRST  in  1  — reset, **synchronous, active-low**.
- input_over  in  1  — input block ready. Sampled only in IDLE.
- CHARACTER_IN  in  1024  — 256 nibbles. Nibble i = CHARACTER_IN[4i+3:4i]; i=0 is the LSB nibble.
- FREQUENT_OUT  out  130  — 10 slots × 13 bits. Slot k (k=0..9) = FREQUENT_OUT[13k+12:13k] = {symbol[3:0] = k+1, freq[8:0]}.
- count_over  out  1  — high when FREQUENT_OUT holds the final counts.

## Operation
- **Symbol handling**
  - Nibble 0 is padding (empty) and is ignored.
  - Nibbles 11..15 are outside the alphabet and are ignored.
  - Nibbles 1..10 increment counter[value-1].
- **Counters**: ten 9-bit counters. Maximum possible count is 256, which fits in 9 bits, so no saturation is needed.
- **FSM states and transitions**
  - IDLE: counters cleared, idx = 0. If input_over = 1, latch CHARACTER_IN into a 1024-bit internal register and go to COUNT.
  - COUNT: each cycle, examine latched nibble idx, update the matching counter, then idx += 1. When idx = 255 is processed, go to DONE.
  - DONE: terminal state. Holds outputs until reset; input_over is ignored.
- **Input capture**: CHARACTER_IN and input_over changes after the capture edge have no effect on the result.
- **Output register**
  - FREQUENT_OUT is loaded on the same edge that processes nibble 255, using final counts that include nibble 255.
  - Symbol fields are constant 1..10 in every slot, including slots whose count is zero.
- **Reset values**
  - FREQUENT_OUT = 0 (all 130 bits, including symbol fields), count_over = 0, state = IDLE, counters = 0, idx = 0.

## Timing
- Edge numbering: edge E0 is the first rising edge with nRST = 1 and input_over = 1 while in IDLE (the capture edge).
- Edges E1..E256 process nibbles 0..255.
- At E256: FREQUENT_OUT is loaded and count_over rises. Both are valid from just after E256 and remain stable until reset.
- Latency from capture to count_over is 256 cycles, fixed and independent of data.
- If input_over is already high when reset is released, capture occurs on the first edge with nRST = 1.
- nRST low on any edge, including mid-COUNT or in DONE, aborts the block and restores all reset values on that edge. A new block starts only after returning to IDLE.
- Between reset and E256, count_over = 0 and FREQUENT_OUT = 0.
- No back-pressure: the downstream stage samples the outputs any time count_over = 1.

## Test plan
- **Reference block**: low nibbles (LSB first) are 1,2,3,4,5,1,1,1,2,1,2,1,2,3,1,2,3,4,1,2,3,4,1,2,3,4,1,2,3,4,5; all upper nibbles 0; input_over = 1 through reset.
  - After E256, count_over = 1.
  - Slots 0..4 = {1,10}, {2,8}, {3,6}, {4,5}, {5,2}.
  - Slots 5..9 = {6..10, 0}.
  - count_over = 0 before E256.
- **All-zero block**: count_over after E256. Every slot is {k+1, 0}.
- **All nibbles = 7**: slot 6 = {7, 256}; all other counts 0. Also include 11..15 nibbles mixed with 10s, which must leave only slot 9 counting the 10s.
- **input_over held low for 50 cycles after reset**: count_over stays 0 and FREQUENT_OUT stays 0. Raise input_over; count_over rises exactly 256 edges after the capture edge.
- **Reset mid-operation**: assert nRST = 0 at E100, then release with a different block.
  - Outputs are 0 immediately after the reset edge.
  - Final counts reflect only the second block.
- **Input change after capture**: change CHARACTER_IN at E5. Results match the block captured at E0.
